// File: rtl/vb_pkg.sv
// Shared definitions for the victim write-back drain engine: eviction entry
// bit layout, drain FSM states and the "needs write-back" predicate.
package vb_pkg;

    localparam int VB_VALID_BIT = 79;
    localparam int VB_DIRTY_BIT = 78;
    localparam int VB_ADDR_HI   = 77;
    localparam int VB_ADDR_LO   = 64;
    localparam int VB_DATA_W    = 64;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_RECOVER = 2'd2
    } vb_state_t;

    // Only entries that are both valid and dirty carry data memory lacks.
    function automatic logic vb_needs_writeback(input logic [VB_VALID_BIT:0] entry);
        return entry[VB_VALID_BIT] & entry[VB_DIRTY_BIT];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular queue of pending write-backs. Exposes every slot plus an occupied
// mask so the parent can snoop the whole queue combinationally.
module wb_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 14,
    parameter  int DATA_W = 64,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [ADDR_W-1:0]              push_addr,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic [ADDR_W-1:0]              head_addr,
    output logic [DATA_W-1:0]              head_data,
    output logic [CNT_W-1:0]               count,
    output logic                           full,
    output logic                           empty,
    output logic [PTR_W-1:0]               rd_ptr,
    output logic [DEPTH-1:0]               occupied,
    output logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr,
    output logic [DEPTH-1:0][DATA_W-1:0]   entry_data
);

    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign head_addr = entry_addr[rd_ptr];
    assign head_data = entry_data[rd_ptr];

    // Storage needs no reset: the occupied mask hides stale slots.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            entry_addr[wr_ptr] <= push_addr;
            entry_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A slot is live when its distance from the head is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_occ
        logic [PTR_W-1:0] offset;
        assign offset      = PTR_W'(i) - rd_ptr;
        assign occupied[i] = ({1'b0, offset} < count);
    end

endmodule

// File: rtl/victim_writeback.sv
// L1 victim write-back drain: queues dirty evictions, writes them to memory
// one at a time over a hold-until-ack handshake, and serves miss-path snoops.
module victim_writeback
    import vb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ev_valid,
    input  logic [VB_VALID_BIT:0]      ev_data,
    output logic                       ev_ready,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_ack,
    input  logic [ADDR_W-1:0]          snoop_addr,
    output logic                       snoop_hit,
    output logic [DATA_W-1:0]          snoop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);

    localparam int PTR_W = $clog2(DEPTH);

    vb_state_t                        state;
    logic                             full;
    logic                             empty;
    logic                             push;
    logic                             pop;
    logic [ADDR_W-1:0]                head_addr;
    logic [DATA_W-1:0]                head_data;
    logic [PTR_W-1:0]                 rd_ptr;
    logic [DEPTH-1:0]                 occupied;
    logic [DEPTH-1:0][ADDR_W-1:0]     entry_addr;
    logic [DEPTH-1:0][DATA_W-1:0]     entry_data;
    logic [PTR_W-1:0]                 idx;

    // Clean or invalid evictions are accepted but never stored.
    assign ev_ready = ~full;
    assign push     = ev_valid & ev_ready & vb_needs_writeback(ev_data);
    assign pop      = (state == S_WRITE) & mem_we & mem_ack;
    assign busy     = ~empty | (state != S_IDLE);

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (ev_data[VB_ADDR_LO +: ADDR_W]),
        .push_data  (ev_data[DATA_W-1:0]),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .rd_ptr     (rd_ptr),
        .occupied   (occupied),
        .entry_addr (entry_addr),
        .entry_data (entry_data)
    );

    // The head is only popped on ack, so it stays snoopable while in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= head_addr;
                        mem_wdata <= head_data;
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        state  <= S_RECOVER;
                    end
                end
                S_RECOVER: state <= S_IDLE;
                default: begin
                    mem_we <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        snoop_hit  = 1'b0;
        snoop_data = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (occupied[idx] && entry_addr[idx] == snoop_addr) begin
                snoop_hit  = 1'b1;
                snoop_data = entry_data[idx];
            end
        end
    end

endmodule

// File: tb/tb_victim_writeback.sv
// Bench for victim_writeback: directed scenarios plus a randomized run scored
// against a queue-based reference model of the drain engine.
module tb_victim_writeback;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 64;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ev_valid = 1'b0;
    logic [79:0]         ev_data = '0;
    logic                ev_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_ack = 1'b0;
    logic [ADDR_W-1:0]   snoop_addr = '0;
    logic                snoop_hit;
    logic [DATA_W-1:0]   snoop_data;
    logic [2:0]          count;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    victim_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ev_valid   (ev_valid),
        .ev_data    (ev_data),
        .ev_ready   (ev_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .snoop_addr (snoop_addr),
        .snoop_hit  (snoop_hit),
        .snoop_data (snoop_data),
        .count      (count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: pending write-backs as a queue, an in-flight write,
    // and a cooldown counter standing for the one idle cycle after each ack.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              q[$];
    bit                m_we   = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    int                m_gap  = 0;
    int                m_pending;
    bit                m_accept;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_we   = 0;
            m_addr = '0;
            m_data = '0;
            m_gap  = 0;
        end else begin
            m_pending = q.size();
            m_accept  = ev_valid && (m_pending < DEPTH);
            if (m_we) begin
                if (mem_ack) begin
                    m_we = 0;
                    q.delete(0);
                    m_gap = 1;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (m_pending > 0) begin
                m_we   = 1;
                m_addr = q[0].a;
                m_data = q[0].d;
            end
            if (m_accept && ev_data[79] && ev_data[78])
                q.push_back('{a: ev_data[77:64], d: ev_data[63:0]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ev_valid = 1'b0;
        mem_ack  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ev_valid = 1'b1;
        ev_data  = {1'b1, 1'b1, a, d};
        step();
        ev_valid = 1'b0;
    endtask

    task automatic wait_we(input int budget, output bit ok);
        int n;
        n = 0;
        while (!mem_we && n < budget) begin
            step();
            n++;
        end
        ok = mem_we;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mem got we=%0b addr=%h data=%h exp 0/0/0", mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (count !== 3'd0 || busy !== 1'b0 || ev_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_status got count=%0d busy=%0b ready=%0b exp 0/0/1", count, busy, ev_ready);
        end
        checks++;
        if (snoop_hit !== 1'b0 || snoop_data !== '0) begin
            failures++;
            $display("[TB] FAIL reset_snoop got hit=%0b data=%h exp 0/0", snoop_hit, snoop_data);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        push_one(14'h0123, 64'hDEADBEEF00000001);
        checks++;
        if (count !== 3'd1 || mem_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_push got count=%0d we=%0b exp 1/0", count, mem_we);
        end
        step();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 14'h0123 || mem_wdata !== 64'hDEADBEEF00000001) begin
            failures++;
            $display("[TB] FAIL single_issue got we=%0b addr=%h data=%h exp 1/0123/deadbeef00000001", mem_we, mem_addr, mem_wdata);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 14'h0123 || mem_wdata !== 64'hDEADBEEF00000001 || count !== 3'd1) begin
                failures++;
                $display("[TB] FAIL single_hold cycle %0d got we=%0b addr=%h count=%0d exp 1/0123/1", i, mem_we, mem_addr, count);
            end
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++;
        if (count !== 3'd0 || mem_we !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_ack got count=%0d we=%0b busy=%0b exp 0/0/1", count, mem_we, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_idle got busy=%0b we=%0b exp 0/0", busy, mem_we);
        end
    endtask

    task automatic test_clean_discard();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ev_valid = 1'b1;
            ev_data  = {(i >= 3) ? 1'b0 : 1'b1, (i >= 3) ? 1'b1 : 1'b0, 14'(16'h0050 + i), 64'(i)};
            step();
            checks++;
            if (ev_ready !== 1'b1 || count !== 3'd0 || mem_we !== 1'b0) begin
                failures++;
                $display("[TB] FAIL clean_discard entry %0d got ready=%0b count=%0d we=%0b exp 1/0/0", i, ev_ready, count, mem_we);
            end
        end
        ev_valid = 1'b0;
        step();
        step();
        checks++;
        if (mem_we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clean_no_write got we=%0b busy=%0b exp 0/0", mem_we, busy);
        end
    endtask

    task automatic test_fill_and_order();
        logic [ADDR_W-1:0] seen_addr[$];
        int                seen_cyc[$];
        do_reset();
        for (int i = 0; i < 4; i++) push_one(14'(16'h0010 + i), {32'hA5A5_0000, 32'(i)});
        checks++;
        if (ev_ready !== 1'b0 || count !== 3'd4) begin
            failures++;
            $display("[TB] FAIL fill_full got ready=%0b count=%0d exp 0/4", ev_ready, count);
        end
        push_one(14'h0014, 64'h14);
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("[TB] FAIL fill_reject got count=%0d exp 4", count);
        end
        mem_ack = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (mem_we) begin
                seen_addr.push_back(mem_addr);
                seen_cyc.push_back(c);
            end
            step();
        end
        mem_ack = 1'b0;
        checks++;
        if (seen_addr.size() != 4) begin
            failures++;
            $display("[TB] FAIL fill_write_count got %0d writes exp 4", seen_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seen_addr[i] !== 14'(16'h0010 + i)) begin
                    failures++;
                    $display("[TB] FAIL fill_order write %0d got addr=%h exp %h", i, seen_addr[i], 14'(16'h0010 + i));
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (seen_cyc[i] - seen_cyc[i-1] != 3) begin
                    failures++;
                    $display("[TB] FAIL fill_spacing write %0d got gap=%0d exp 3", i, seen_cyc[i] - seen_cyc[i-1]);
                end
            end
        end
        checks++;
        if (count !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_drained got count=%0d busy=%0b exp 0/0", count, busy);
        end
    endtask

    task automatic test_snoop_youngest();
        bit ok;
        do_reset();
        push_one(14'h0200, 64'hAAAA_AAAA_0000_0001);
        push_one(14'h0200, 64'hBBBB_BBBB_0000_0002);
        snoop_addr = 14'h0201;
        #1;
        checks++;
        if (snoop_hit !== 1'b0 || snoop_data !== '0) begin
            failures++;
            $display("[TB] FAIL snoop_miss got hit=%0b data=%h exp 0/0", snoop_hit, snoop_data);
        end
        snoop_addr = 14'h0200;
        #1;
        checks++;
        if (snoop_hit !== 1'b1 || snoop_data !== 64'hBBBB_BBBB_0000_0002) begin
            failures++;
            $display("[TB] FAIL snoop_two got hit=%0b data=%h exp 1/bbbbbbbb00000002", snoop_hit, snoop_data);
        end
        wait_we(8, ok);
        checks++;
        if (!ok || mem_wdata !== 64'hAAAA_AAAA_0000_0001) begin
            failures++;
            $display("[TB] FAIL snoop_first_write got we=%0b data=%h exp 1/aaaaaaaa00000001", mem_we, mem_wdata);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++;
        if (snoop_hit !== 1'b1 || snoop_data !== 64'hBBBB_BBBB_0000_0002 || count !== 3'd1) begin
            failures++;
            $display("[TB] FAIL snoop_after_first got hit=%0b data=%h count=%0d exp 1/bbbbbbbb00000002/1", snoop_hit, snoop_data, count);
        end
        wait_we(8, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL snoop_second_write got we=%0b exp 1 within 8 cycles", mem_we);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++;
        if (snoop_hit !== 1'b0 || snoop_data !== '0) begin
            failures++;
            $display("[TB] FAIL snoop_after_second got hit=%0b data=%h exp 0/0", snoop_hit, snoop_data);
        end
    endtask

    task automatic test_push_full_with_pop();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) push_one(14'(16'h0020 + i), 64'(16'h0020 + i));
        wait_we(8, ok);
        checks++;
        if (!ok || count !== 3'd4) begin
            failures++;
            $display("[TB] FAIL fullpop_setup got we=%0b count=%0d exp 1/4", mem_we, count);
        end
        ev_valid = 1'b1;
        ev_data  = {2'b11, 14'h0030, 64'h30};
        mem_ack  = 1'b1;
        step();
        mem_ack = 1'b0;
        checks++;
        if (count !== 3'd3 || ev_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL fullpop_reject got count=%0d ready=%0b exp 3/1", count, ev_ready);
        end
        ev_data = {2'b11, 14'h0031, 64'h31};
        step();
        ev_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("[TB] FAIL fullpop_accept got count=%0d exp 4", count);
        end
        snoop_addr = 14'h0030;
        #1;
        checks++;
        if (snoop_hit !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fullpop_rejected_absent got hit=%0b exp 0", snoop_hit);
        end
        snoop_addr = 14'h0031;
        #1;
        checks++;
        if (snoop_hit !== 1'b1 || snoop_data !== 64'h31) begin
            failures++;
            $display("[TB] FAIL fullpop_accepted_present got hit=%0b data=%h exp 1/31", snoop_hit, snoop_data);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        do_reset();
        for (int i = 0; i < 3; i++) push_one(14'(16'h0040 + i), 64'(16'h0040 + i));
        wait_we(8, ok);
        snoop_addr = 14'h0041;
        rst     = 1'b1;
        mem_ack = 1'b1;
        step();
        rst     = 1'b0;
        mem_ack = 1'b0;
        checks++;
        if (!ok || mem_we !== 1'b0 || count !== 3'd0 || snoop_hit !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset got setup_we=%0b we=%0b count=%0d hit=%0b exp 1/0/0/0", ok, mem_we, count, snoop_hit);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mem_we !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midreset_stray_ack cycle %0d got we=%0b count=%0d busy=%0b exp 0/0/0", i, mem_we, count, busy);
            end
        end
    endtask

    task automatic test_random();
        bit                exp_hit;
        logic [DATA_W-1:0] exp_sd;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst        = ($urandom_range(0, 99) == 0);
            ev_valid   = ($urandom_range(0, 2) != 0);
            ev_data    = {($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                          14'($urandom_range(0, 7)), $urandom, $urandom};
            mem_ack    = ($urandom_range(0, 2) == 0);
            snoop_addr = 14'($urandom_range(0, 7));
            step();
            exp_hit = 0;
            exp_sd  = '0;
            foreach (q[j]) begin
                if (q[j].a == snoop_addr) begin
                    exp_hit = 1;
                    exp_sd  = q[j].d;
                end
            end
            checks++;
            if (mem_we !== m_we || mem_addr !== m_addr || mem_wdata !== m_data) begin
                failures++;
                $display("[TB] FAIL rand_mem cycle %0d got we=%0b addr=%h data=%h exp %0b/%h/%h", cyc, mem_we, mem_addr, mem_wdata, m_we, m_addr, m_data);
            end
            checks++;
            if (count !== 3'(q.size()) || ev_ready !== (q.size() < DEPTH) || busy !== (q.size() != 0 || m_we || m_gap != 0)) begin
                failures++;
                $display("[TB] FAIL rand_status cycle %0d got count=%0d ready=%0b busy=%0b exp count=%0d", cyc, count, ev_ready, busy, q.size());
            end
            checks++;
            if (snoop_hit !== exp_hit || snoop_data !== exp_sd) begin
                failures++;
                $display("[TB] FAIL rand_snoop cycle %0d got hit=%0b data=%h exp %0b/%h", cyc, snoop_hit, snoop_data, exp_hit, exp_sd);
            end
        end
        rst      = 1'b0;
        ev_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_clean_discard();
        test_fill_and_order();
        test_snoop_youngest();
        test_push_full_with_pop();
        test_reset_mid_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/victim_writeback.md
# victim_writeback

Write-back drain engine for the L1 victim path. Accepts evicted 80-bit victim entries ({valid, dirty, addr[13:0], data[63:0]}), queues the dirty ones in a small FIFO, and writes each to main memory over a hold-until-ack write handshake. It sits between the victim buffer's eviction output and the memory controller. A combinational snoop port lets the miss path fetch data still waiting in the queue, so a pending write-back is never bypassed.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- ADDR_W, 14: line address width.
- DATA_W, 64: line data width.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- ev_valid  in  1  eviction entry offered this cycle.
- ev_data  in  80  {valid[79], dirty[78], addr[77:64], data[63:0]}.
- ev_ready  out  1  queue can take an entry; equals !full.
- mem_we  out  1  memory write request; registered.
- mem_addr  out  ADDR_W  write address; registered; stable while mem_we=1.
- mem_wdata  out  DATA_W  write data; registered; stable while mem_we=1.
- mem_ack  in  1  memory accepted the write; sampled only while mem_we=1.
- snoop_addr  in  ADDR_W  miss-path lookup address.
- snoop_hit  out  1  snoop_addr matches a queued entry; combinational.
- snoop_data  out  DATA_W  data of the youngest matching entry; 0 when there is no hit.
- count  out  log2(DEPTH)+1  number of occupied entries.
- busy  out  1  count!=0 or FSM not in IDLE.

## Operation
- Handshake: an entry transfers when ev_valid & ev_ready.
  - It is enqueued only if ev_data[79] & ev_data[78].
  - Clean or invalid entries are accepted and discarded; count does not change.
- FSM has three states: IDLE, WRITE, RECOVER.
  - IDLE: if count!=0, load the head into mem_addr and mem_wdata, set mem_we=1, go to WRITE.
  - WRITE: hold mem_we, mem_addr and mem_wdata. On mem_ack, pop the head, clear mem_we, go to RECOVER.
  - RECOVER: one idle cycle with mem_we=0, then go to IDLE.
- The head stays in the queue, and visible to snoop, until its ack. Pop happens at the ack edge.
- Simultaneous push and pop in one cycle are both applied; count is unchanged.
- ev_ready is based on full only. It does not look ahead to a same-cycle pop.
- Snoop compares snoop_addr with every occupied entry, head included. If several entries match, the youngest wins.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full means count==DEPTH; empty means count==0.
- No coalescing: two evictions of the same address occupy two entries and are written in order.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, count=0, busy=0, ev_ready=1, snoop_hit=0, snoop_data=0. FSM is in IDLE.
- Reset applied mid-WRITE: the queue is flushed and mem_we=0 from the cycle after the reset edge. A mem_ack arriving during reset is ignored.
- Latency into an empty queue: entry pushed at edge N → count=1 after N → FSM leaves IDLE at N+1 → mem_we=1 during the cycle after N+1.
- Back-to-back throughput: ack at edge M → mem_we=0 after M (RECOVER) → IDLE at M+1 → next mem_we=1 after M+2. One write per 3 cycles with zero-wait memory.
- A push at edge N is visible to snoop from the cycle after N. A pop at edge M removes the entry from snoop after M.
- mem_ack while mem_we=0 has no effect.

## Structure
- Shared package `vb_pkg`:
  - bit positions VB_VALID_BIT=79, VB_DIRTY_BIT=78, VB_ADDR_HI=77, VB_ADDR_LO=64, VB_DATA_W=64;
  - FSM state encodings S_IDLE=2'd0, S_WRITE=2'd1, S_RECOVER=2'd2.
- One sub-module, `wb_fifo`: storage array, wrap pointers, count, push/pop, and a per-entry occupied mask exported for the snoop compare.
- FSM, output registers and snoop priority logic live in the top module.

## Test plan
- Reset, then offer {v=1,d=1,addr=0x0123,data=0xDEADBEEF00000001} → mem_we=1 two cycles after the push with addr 0x0123 and that data. Hold mem_ack=0 for 5 cycles → outputs stable, count=1. Ack → count=0, busy=0 two cycles later.
- Offer entries with d=0, then v=0 → ev_ready=1, count stays 0, mem_we never asserts.
- Push 4 dirty entries (addr 0x10 through 0x13) with mem_ack held low → ev_ready=0 after the 4th. A 5th offer is not accepted. Release ack each cycle → writes issue in order 0x10, 0x11, 0x12, 0x13, spaced 3 cycles apart.
- Queue addr 0x0200 twice with data A then B → snoop_addr=0x0200 gives hit=1, data=B. After the first ack, still hit with B. After the second ack, hit=0 and data=0.
- Push while full at the same edge as a head ack → push is rejected, count drops to 3. Push in the next cycle is accepted.
- Assert rst during WRITE with 3 entries queued → the cycle after the reset edge shows mem_we=0, count=0, snoop_hit=0. A later mem_ack pulse is ignored.
